// File: rtl/alu_sequencer_pkg.sv
// Shared constants and types for the ALU program sequencer and the frame controller.
package alu_sequencer_pkg;
  localparam int PROG_ADDR_BITS = 7;
  localparam int PROG_SIZE      = 100;
  localparam int SERIAL_CYCLES  = 4;
  localparam int NUM_ALU_REGS   = 7;
  localparam int HALT_BIT       = 6;
  localparam int TAG_BITS       = 3;
  localparam int PHASE_BITS     = $clog2(SERIAL_CYCLES);

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  typedef logic [TAG_BITS-1:0] tag_t;

  // Tag codes carried in the ROM and decoded by the frame/pixel controller.
  localparam tag_t TAG_NONE       = 3'd0;
  localparam tag_t TAG_ROW_END    = 3'd1;
  localparam tag_t TAG_PIX_LOAD   = 3'd2;
  localparam tag_t TAG_PIX_STORE  = 3'd3;
  localparam tag_t TAG_ACC_CLEAR  = 3'd4;
  localparam tag_t TAG_FRAME_SYNC = 3'd5;
  localparam tag_t TAG_FLUSH      = 3'd6;

  function automatic logic is_last_addr(input logic [PROG_ADDR_BITS-1:0] a);
    return a == PROG_ADDR_BITS'(PROG_SIZE - 1);
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// Sequencer <-> ROM / frame controller signal bundle.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic                      start;
  logic                      abort;
  logic                      stall;
  logic [NUM_ALU_REGS-1:0]   dmask_in;
  logic [TAG_BITS-1:0]       tag_in;
  logic [PROG_ADDR_BITS-1:0] addr;
  logic [PHASE_BITS-1:0]     phase;
  logic                      first_phase;
  logic                      last_phase;
  logic                      busy;
  logic                      done;
  logic                      tag_strobe;
  logic [TAG_BITS-1:0]       tag_out;

  modport master (
    output start, abort, stall, dmask_in, tag_in,
    input  addr, phase, first_phase, last_phase, busy, done, tag_strobe, tag_out
  );

  modport slave (
    input  start, abort, stall, dmask_in, tag_in,
    output addr, phase, first_phase, last_phase, busy, done, tag_strobe, tag_out
  );
endinterface

// File: rtl/alu_phase_counter.sv
// Modulo-MODULUS phase counter; wraps at MODULUS-1 rather than at a power of two.
module alu_phase_counter #(
  parameter int MODULUS = 4,
  parameter int WIDTH   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_phase,
  output logic             o_last
);
  logic [WIDTH-1:0] r_phase;
  logic             w_last;

  assign w_last  = (r_phase == WIDTH'(MODULUS - 1));
  assign o_phase = r_phase;
  assign o_last  = w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= w_last ? '0 : r_phase + WIDTH'(1);
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// ALU microprogram sequencer: ROM address generation, bit-serial phase timing,
// halt detection and tag/done event reporting.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  alu_sequencer_if.slave  bus
);
  seq_state_t                r_state;
  logic [PROG_ADDR_BITS-1:0] r_addr;
  logic                      r_done;
  logic                      r_tag_strobe;
  tag_t                      r_tag_out;

  logic                      w_busy;
  logic                      w_last;
  logic [PHASE_BITS-1:0]     w_phase;
  logic                      w_retire;
  logic                      w_halt;

  assign w_busy   = (r_state == SEQ_RUN);
  // Abort outranks retire, so a halt instruction being aborted reports nothing.
  assign w_retire = w_busy && w_last && !bus.stall && !bus.abort;
  assign w_halt   = bus.dmask_in[HALT_BIT] || is_last_addr(r_addr);

  alu_phase_counter #(
    .MODULUS (SERIAL_CYCLES),
    .WIDTH   (PHASE_BITS)
  ) u_phase (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (bus.abort || !w_busy),
    .i_en    (w_busy && !bus.stall),
    .o_phase (w_phase),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= SEQ_IDLE;
      r_addr       <= '0;
      r_done       <= 1'b0;
      r_tag_strobe <= 1'b0;
      r_tag_out    <= TAG_NONE;
    end else begin
      r_done       <= 1'b0;
      r_tag_strobe <= 1'b0;
      if (bus.abort) begin
        r_state <= SEQ_IDLE;
        r_addr  <= '0;
      end else begin
        case (r_state)
          SEQ_IDLE: begin
            r_addr <= '0;
            if (bus.start) r_state <= SEQ_RUN;
          end
          SEQ_RUN: begin
            if (w_retire) begin
              if (bus.tag_in != TAG_NONE) begin
                r_tag_strobe <= 1'b1;
                r_tag_out    <= bus.tag_in;
              end
              if (w_halt) begin
                r_state <= SEQ_IDLE;
                r_addr  <= '0;
                r_done  <= 1'b1;
              end else begin
                r_addr <= r_addr + PROG_ADDR_BITS'(1);
              end
            end
          end
          default: begin
            r_state <= SEQ_IDLE;
            r_addr  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.addr        = r_addr;
  assign bus.phase       = w_phase;
  assign bus.first_phase = w_busy && (w_phase == '0);
  assign bus.last_phase  = w_busy && w_last;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.tag_strobe  = r_tag_strobe;
  assign bus.tag_out     = r_tag_out;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a combinational ROM model and tag-event scoreboard.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequencer_if sif();

  alu_sequencer dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (sif.slave)
  );

  int rom_mode = 0;
  int n_pass   = 0;
  int n_total  = 0;

  typedef struct {
    int                  cyc;
    logic [TAG_BITS-1:0] tag;
  } ev_t;
  ev_t sb_q[$];

  function automatic logic [TAG_BITS-1:0] rom_tag(input int mode, input int a);
    if (mode == 1 && a == 5) return 3'd2;
    case (a)
      20, 27, 44, 51: return 3'd3;
      74, 82:         return 3'd4;
      84:             return 3'd2;
      91:             return 3'd1;
      62:             return 3'd5;
      95:             return 3'd6;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [NUM_ALU_REGS-1:0] rom_dmask(input int mode, input int a);
    if (a == 99 || (mode == 1 && a == 5)) return 7'h40;
    return NUM_ALU_REGS'(a % 64);
  endfunction

  assign sif.dmask_in = rom_dmask(rom_mode, int'(sif.addr));
  assign sif.tag_in   = rom_tag(rom_mode, int'(sif.addr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.stall = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_total++;
    if ({sif.busy, sif.addr, sif.phase, sif.done, sif.tag_strobe, sif.tag_out,
         sif.first_phase, sif.last_phase} !== '0)
      $display("FAIL reset_state: busy=%0b addr=%0d phase=%0d done=%0b strobe=%0b tag_out=%0d, expected all zero",
               sif.busy, sif.addr, sif.phase, sif.done, sif.tag_strobe, sif.tag_out);
    else n_pass++;
  endtask

  // Full run from start to completion; stall_len cycles of stall begin after sample stall_at.
  task automatic run_program(input string name, input int halt_k,
                             input int stall_at, input int stall_len);
    int   n, pos, done_cnt, done_cyc, p, exp_end;
    logic stall_now;
    ev_t  ev;
    sb_q.delete();
    for (int k = 0; k <= halt_k; k++) begin
      if (rom_tag(rom_mode, k) != 3'd0) begin
        p = SERIAL_CYCLES * (k + 1);
        sb_q.push_back('{p + ((stall_len > 0 && p > stall_at) ? stall_len : 0),
                         rom_tag(rom_mode, k)});
      end
    end
    exp_end = SERIAL_CYCLES * (halt_k + 1) + stall_len;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n = 0; pos = 0; done_cnt = 0; done_cyc = -1;
    while (n <= exp_end + 20) begin
      if (sif.tag_strobe) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL %s unexpected_strobe: cycle %0d tag_out=%0d, expected no strobe",
                   name, n, sif.tag_out);
        end else begin
          ev = sb_q.pop_front();
          if (n !== ev.cyc || sif.tag_out !== ev.tag)
            $display("FAIL %s tag_event: cycle %0d tag_out=%0d, expected cycle %0d tag_out=%0d",
                     name, n, sif.tag_out, ev.cyc, ev.tag);
          else n_pass++;
        end
      end
      if (sif.done) begin
        done_cnt++;
        done_cyc = n;
      end
      if (!sif.busy) break;
      n_total++;
      if ({sif.addr, sif.phase} !== {PROG_ADDR_BITS'(pos / SERIAL_CYCLES),
                                     PHASE_BITS'(pos % SERIAL_CYCLES)})
        $display("FAIL %s addr_phase: cycle %0d addr=%0d phase=%0d, expected addr=%0d phase=%0d",
                 name, n, sif.addr, sif.phase, pos / SERIAL_CYCLES, pos % SERIAL_CYCLES);
      else n_pass++;
      stall_now = (stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
      sif.stall = stall_now;
      tick();
      n++;
      if (!stall_now) pos++;
    end
    sif.stall = 1'b0;
    n_total++;
    if (n !== exp_end)
      $display("FAIL %s busy_length: got %0d cycles, expected %0d", name, n, exp_end);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || done_cyc !== exp_end)
      $display("FAIL %s done_pulse: count=%0d cycle=%0d, expected count=1 cycle=%0d",
               name, done_cnt, done_cyc, exp_end);
    else n_pass++;
    n_total++;
    if (sb_q.size() !== 0)
      $display("FAIL %s missing_strobes: %0d outstanding, expected 0", name, sb_q.size());
    else n_pass++;
    n_total++;
    if ({sif.addr, sif.phase} !== '0)
      $display("FAIL %s end_addr: addr=%0d phase=%0d, expected 0 0", name, sif.addr, sif.phase);
    else n_pass++;
  endtask

  task automatic test_abort();
    rom_mode = 0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (201) tick();
    n_total++;
    if ({sif.busy, sif.addr, sif.phase} !== {1'b1, 7'd50, 2'd1})
      $display("FAIL abort_pre: busy=%0b addr=%0d phase=%0d, expected 1 50 1",
               sif.busy, sif.addr, sif.phase);
    else n_pass++;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    n_total++;
    if ({sif.busy, sif.addr, sif.phase, sif.done, sif.tag_strobe} !== '0)
      $display("FAIL abort_effect: busy=%0b addr=%0d phase=%0d done=%0b strobe=%0b, expected all zero",
               sif.busy, sif.addr, sif.phase, sif.done, sif.tag_strobe);
    else n_pass++;
    tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n_total++;
    if ({sif.busy, sif.addr, sif.phase, sif.first_phase} !== {1'b1, 7'd0, 2'd0, 1'b1})
      $display("FAIL abort_restart: busy=%0b addr=%0d phase=%0d first=%0b, expected 1 0 0 1",
               sif.busy, sif.addr, sif.phase, sif.first_phase);
    else n_pass++;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    // Abort landing on the retire of a halt instruction suppresses done and strobe.
    rom_mode = 1;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (23) tick();
    n_total++;
    if ({sif.addr, sif.phase, sif.last_phase} !== {7'd5, 2'd3, 1'b1})
      $display("FAIL abort_halt_pre: addr=%0d phase=%0d last=%0b, expected 5 3 1",
               sif.addr, sif.phase, sif.last_phase);
    else n_pass++;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    n_total++;
    if ({sif.busy, sif.done, sif.tag_strobe} !== 3'b000)
      $display("FAIL abort_halt: busy=%0b done=%0b strobe=%0b, expected 0 0 0",
               sif.busy, sif.done, sif.tag_strobe);
    else n_pass++;
    rom_mode = 0;
  endtask

  task automatic test_start_ignored();
    int n;
    rom_mode = 0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (120) tick();
    n = 120;
    for (int i = 0; i < 3; i++) begin
      sif.start = 1'b1;
      tick();
      n++;
      n_total++;
      if ({sif.busy, sif.addr, sif.phase} !== {1'b1, 7'd30, PHASE_BITS'(n % 4)})
        $display("FAIL start_while_busy: busy=%0b addr=%0d phase=%0d, expected 1 30 %0d",
                 sif.busy, sif.addr, sif.phase, n % 4);
      else n_pass++;
    end
    sif.start = 1'b0;
    sif.abort = 1'b1;
    tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    n_total++;
    if ({sif.busy, sif.addr} !== {1'b0, 7'd0})
      $display("FAIL start_abort_idle: busy=%0b addr=%0d, expected 0 0", sif.busy, sif.addr);
    else n_pass++;
    tick();
    n_total++;
    if (sif.busy !== 1'b0)
      $display("FAIL start_abort_idle_hold: busy=%0b, expected 0", sif.busy);
    else n_pass++;
  endtask

  task automatic test_early_halt();
    rom_mode = 1;
    run_program("early_halt", 5, 0, 0);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n_total++;
    if ({sif.busy, sif.addr, sif.phase} !== {1'b1, 7'd0, 2'd0})
      $display("FAIL start_after_done: busy=%0b addr=%0d phase=%0d, expected 1 0 0",
               sif.busy, sif.addr, sif.phase);
    else n_pass++;
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    rom_mode = 0;
  endtask

  initial begin
    test_reset();
    rom_mode = 0;
    run_program("full_run", 99, 0, 0);
    tick();
    run_program("stall_run", 99, 43, 5);
    tick();
    test_abort();
    tick();
    test_start_ignored();
    tick();
    test_early_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
